hack_data_memory: RTL and testbench
===================================

Name: hack_data_memory

Overview:
- Responder side of the CPU data-memory bus: the CPU drives address/write/data_in; this block returns data_out, which feeds the CPU's inM.
- Implements the Hack memory map: RAM, screen buffer and keyboard register.
- Adds a sequential screen scanner that streams screen words to a display sink over a valid/ready handshake.
- Adds a keyboard capture port with its own handshake.

Parameters:
- RAM_WORDS, 16384, data RAM depth at addresses 0..RAM_WORDS-1.
- SCREEN_BASE, 16384, first screen address.
- SCREEN_WORDS, 8192, screen buffer depth; the scan counter is log2(SCREEN_WORDS) bits.
- KBD_ADDR, 24576, keyboard register address.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  16  CPU addressM.
- write  in  1  CPU writeM; write strobe.
- data_in  in  16  CPU outM; write data.
- data_out  out  16  read data to the CPU's inM.
- kbd_code  in  16  key code from the keyboard source; 0 means no key.
- kbd_valid  in  1  kbd_code is valid.
- kbd_ready  out  1  block can accept a key code.
- scan_data  out  16  screen word being presented.
- scan_addr  out  13  screen word index of scan_data.
- scan_valid  out  1  scan_data/scan_addr are valid.
- scan_ready  in  1  display sink accepts the word.
- frame_start  out  1  presented word is index 0.
- err_addr  out  1  sticky illegal-write flag.

Behaviour:
- Address decode:
  - 0..16383: RAM.
  - 16384..24575: screen, index = address-SCREEN_BASE.
  - 24576: keyboard.
  - 24577..65535: unmapped.
- Reads are combinational: data_out follows address in the same cycle with no clock.
  - Unmapped reads return 0x0000.
  - The keyboard address returns the kbd register.
- Writes occur on the rising edge when write=1.
  - A read of the same address before that edge returns the old value; after the edge it returns the new value.
- Writes to the keyboard or to unmapped addresses are dropped and set err_addr=1 at the edge. err_addr is cleared only by reset.
- Memory contents are not affected by reset. The bench initialises every word before reading it.
- Keyboard path:
  - kbd register is 16 bits; reset value 0x0000.
  - kbd_ready = 0 while reset is asserted and 1 from the first edge after reset release.
  - On an edge with kbd_valid & kbd_ready, kbd <= kbd_code. A code of 0 records key release.
  - When kbd_valid=0, kbd holds its value.
- Scanner FSM, states FETCH and PRESENT; reset state FETCH with ptr=0:
  - FETCH: synchronous read of screen[ptr] on the second screen port; scan_data <= screen[ptr], scan_addr <= ptr; next state PRESENT.
  - PRESENT: scan_valid=1. scan_data and scan_addr hold stable until scan_ready=1 at an edge.
    - On that edge: ptr <= ptr+1, wrapping SCREEN_WORDS-1 -> 0; next state FETCH.
    - If scan_ready=0: stay in PRESENT.
  - Throughput is at most one word per 2 cycles. scan_ready has no effect in FETCH.
- Scanner and CPU-write interaction:
  - A CPU write to screen[ptr] at the same edge as FETCH: the scanner captures the old value (read-before-write).
  - Words already latched in PRESENT are unaffected by later CPU writes.
- frame_start = scan_valid & (scan_addr==0); combinational from registers.
- Reset values: data_out follows decode; kbd_ready=0, scan_valid=0, scan_data=0, scan_addr=0, frame_start=0, err_addr=0.
- Reset asserted mid-operation:
  - Immediately: scan_valid=0, ptr=0, kbd=0, err_addr=0.
  - After release: the first presented word is index 0 with frame_start=1.

Test Plan:
1. Reset; write 0x1234 to address 5 -> data_out at address 5 reads 0x1234 after the edge and the old value before it; address 24577 reads 0x0000.
2. Write 0xFFFF to 16384 and 0x00F0 to 16385; hold scan_ready=1 -> presented words are (0,0xFFFF,frame_start=1) then (1,0x00F0,frame_start=0); scan_valid pulses every other cycle.
3. In PRESENT at scan_addr 0, hold scan_ready=0 for 10 cycles and have the CPU write 0x0000 to 16384 -> scan_valid stays 1 and scan_data stays 0xFFFF; after scan_ready, the next frame's word 0 reads 0x0000.
4. Present kbd_valid with 0x0041 -> address 24576 reads 0x0041 after the edge; then kbd_valid with 0x0000 -> reads 0x0000; with kbd_valid=0 the register holds its value.
5. CPU write 0xBEEF to 24576, then to 30000 -> kbd is unchanged, err_addr=1 from the first write's edge, address 30000 reads 0x0000; err_addr stays 1 until reset.
6. Stream 8192 handshakes -> scan_addr wraps 8191 -> 0 with frame_start=1. Then assert reset while presenting scan_addr 100 -> scan_valid drops immediately; after release the first word is index 0.

Source files
------------

// File: rtl/hack_data_memory_if.sv
// ---------------------------------------------------------------------------
// hack_data_memory_if
//   Signal bundle between the Hack data memory and its three clients: the CPU
//   data bus, the keyboard source and the display sink.
//
//   CPU bus     : address, write, data_in -> memory ; data_out -> CPU (inM)
//   Keyboard    : kbd_code, kbd_valid -> memory ; kbd_ready -> source
//   Display     : scan_data, scan_addr, scan_valid, frame_start -> sink ;
//                 scan_ready -> memory
//   Status      : err_addr -> CPU side (sticky illegal-write flag)
//
//   master : the environment (CPU, keyboard source, display sink)
//   slave  : the data memory itself
// ---------------------------------------------------------------------------
interface hack_data_memory_if #(
  parameter int SCAN_W = 13
);
  logic [15:0]       address;
  logic              write;
  logic [15:0]       data_in;
  logic [15:0]       data_out;

  logic [15:0]       kbd_code;
  logic              kbd_valid;
  logic              kbd_ready;

  logic [15:0]       scan_data;
  logic [SCAN_W-1:0] scan_addr;
  logic              scan_valid;
  logic              scan_ready;
  logic              frame_start;

  logic              err_addr;

  modport master (
    output address, write, data_in,
    output kbd_code, kbd_valid,
    output scan_ready,
    input  data_out, kbd_ready,
    input  scan_data, scan_addr, scan_valid, frame_start,
    input  err_addr
  );

  modport slave (
    input  address, write, data_in,
    input  kbd_code, kbd_valid,
    input  scan_ready,
    output data_out, kbd_ready,
    output scan_data, scan_addr, scan_valid, frame_start,
    output err_addr
  );
endinterface

// File: rtl/hack_data_memory.sv
// ---------------------------------------------------------------------------
// hack_data_memory
//   Responder for the Hack CPU data-memory bus. Implements the Hack memory
//   map (data RAM, screen buffer, keyboard register), a keyboard capture
//   port, and a screen scanner that streams every screen word, in index
//   order and wrapping forever, to a display sink over valid/ready.
//
//   Ports
//     clk   : system clock, all state changes on the rising edge
//     reset : asynchronous, active-high
//     bus   : hack_data_memory_if.slave
//       address/write/data_in -> data_out  CPU bus, combinational read
//       kbd_code/kbd_valid    -> kbd_ready keyboard capture handshake
//       scan_*/frame_start    <- scan_ready display stream handshake
//       err_addr                           sticky illegal-write flag
//
//   Memory map (defaults)
//     0     .. 16383 : data RAM
//     16384 .. 24575 : screen buffer, index = address - SCREEN_BASE
//     24576          : keyboard register (read-only from the CPU)
//     24577 .. 65535 : unmapped, reads 0x0000, writes dropped
// ---------------------------------------------------------------------------
module hack_data_memory #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_BASE  = 16384,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned KBD_ADDR     = 24576
) (
  input logic              clk,
  input logic              reset,
  hack_data_memory_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  localparam logic [SCR_AW-1:0] SCR_LAST = SCR_AW'(SCREEN_WORDS - 1);

  typedef enum logic {
    FETCH   = 1'b0,
    PRESENT = 1'b1
  } scan_state_t;

  // Storage. Neither array is touched by reset.
  logic [DATA_W-1:0] ram    [RAM_WORDS];
  logic [DATA_W-1:0] screen [SCREEN_WORDS];

  // Address decode
  logic [31:0]       addr_ext;
  logic              is_ram;
  logic              is_scr;
  logic              is_kbd;
  logic              is_unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic [DATA_W-1:0] rd_data;

  // Keyboard and status
  logic [DATA_W-1:0] kbd;
  logic              kbd_ready;
  logic              err_addr;

  // Scanner
  scan_state_t       state;
  scan_state_t       state_nxt;
  logic              load_p0;
  logic              adv_p0;
  logic [SCR_AW-1:0] ptr_p0;
  logic [SCR_AW-1:0] ptr_nxt;
  logic [DATA_W-1:0] scan_data_p1;
  logic [SCR_AW-1:0] scan_addr_p1;
  logic              vld_p1;

  // -------------------------------------------------------------------------
  // Decode: the address is widened so range compares against the 32-bit
  // parameters stay unsigned and overflow-free.
  // -------------------------------------------------------------------------
  assign addr_ext    = {16'd0, bus.address};
  assign is_ram      = (addr_ext < RAM_WORDS);
  assign is_scr      = (addr_ext >= SCREEN_BASE) &&
                       (addr_ext <  SCREEN_BASE + SCREEN_WORDS);
  assign is_kbd      = (addr_ext == KBD_ADDR);
  assign is_unmapped = !(is_ram || is_scr || is_kbd);

  assign ram_idx = RAM_AW'(bus.address);
  assign scr_idx = SCR_AW'(addr_ext - SCREEN_BASE);

  // CPU read port: purely combinational, so a read at the address being
  // written shows the old word until the write edge.
  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = ram[ram_idx];
    end else if (is_scr) begin
      rd_data = screen[scr_idx];
    end else if (is_kbd) begin
      rd_data = kbd;
    end
  end

  assign bus.data_out = rd_data;

  // CPU write port. Keyboard and unmapped writes are simply not enabled here;
  // they are flagged through err_addr below.
  always_ff @(posedge clk) begin
    if (bus.write && is_ram) begin
      ram[ram_idx] <= bus.data_in;
    end
    if (bus.write && is_scr) begin
      screen[scr_idx] <= bus.data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Keyboard register, ready flag and sticky illegal-write flag.
  // kbd_ready rises on the first edge after reset release.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd       <= '0;
      kbd_ready <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      kbd_ready <= 1'b1;
      if (bus.kbd_valid && kbd_ready) begin
        kbd <= bus.kbd_code;
      end
      if (bus.write && (is_kbd || is_unmapped)) begin
        err_addr <= 1'b1;
      end
    end
  end

  assign bus.kbd_ready = kbd_ready;
  assign bus.err_addr  = err_addr;

  // -------------------------------------------------------------------------
  // Scanner next-state: FETCH always loads one word and moves to PRESENT;
  // PRESENT waits for the sink and then advances the pointer.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load_p0   = 1'b0;
    adv_p0    = 1'b0;
    case (state)
      FETCH: begin
        load_p0   = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (bus.scan_ready) begin
          adv_p0    = 1'b1;
          state_nxt = FETCH;
        end
      end
    endcase
  end

  assign ptr_nxt = (ptr_p0 == SCR_LAST) ? '0 : ptr_p0 + SCR_AW'(1);

  // --- stage p0 -> p1: synchronous read of the second screen port ----------
  // The read sees the array before any CPU write at the same edge, so the
  // scanner captures the old word; once latched the word is immune to later
  // CPU writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      ptr_p0       <= '0;
      scan_data_p1 <= '0;
      scan_addr_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (load_p0) begin
        scan_data_p1 <= screen[ptr_p0];
        scan_addr_p1 <= ptr_p0;
      end
      if (adv_p0) begin
        ptr_p0 <= ptr_nxt;
      end
    end
  end

  assign vld_p1 = (state == PRESENT);

  assign bus.scan_valid  = vld_p1;
  assign bus.scan_data   = scan_data_p1;
  assign bus.scan_addr   = scan_addr_p1;
  assign bus.frame_start = vld_p1 && (scan_addr_p1 == '0);

endmodule

// File: tb/tb_hack_data_memory.sv
// ---------------------------------------------------------------------------
// tb_hack_data_memory
//   Bench for hack_data_memory: a table of CPU/keyboard cycles, a full
//   screen initialisation, hand-written scanner sequences (stream, stall,
//   frame wrap, reset mid-stream) and a randomized phase, all compared
//   against a behavioural model of the memory map and the word stream.
// ---------------------------------------------------------------------------
module tb_hack_data_memory;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  hack_data_memory_if bus ();

  hack_data_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ram_m [16384];
  logic [15:0] scr_m [8192];
  logic [15:0] kbd_m;
  bit          m_err;
  bit          m_rdy;
  bit          m_present;
  int          m_ptr;
  logic [15:0] m_word;
  bit          scan_chk = 1'b0;
  logic [15:0] pre_dout;

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [15:0] d;
    logic        kv;
    logic [15:0] kc;
    logic        chk_pre;
    logic [15:0] pre;
    logic [15:0] post;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 16384) return ram_m[ai];
    if (ai < 24576) return scr_m[ai - 16384];
    if (ai == 24576) return kbd_m;
    return 16'h0000;
  endfunction

  // Model of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    int a;
    a = int'(bus.address);
    if (!m_present) begin
      m_word    = scr_m[m_ptr];
      m_present = 1'b1;
    end else if (bus.scan_ready) begin
      m_ptr     = (m_ptr + 1) % 8192;
      m_present = 1'b0;
    end
    if (bus.write) begin
      if (a < 16384) ram_m[a] = bus.data_in;
      else if (a < 24576) scr_m[a - 16384] = bus.data_in;
      else m_err = 1'b1;
    end
    if (bus.kbd_valid && m_rdy) kbd_m = bus.kbd_code;
    m_rdy = 1'b1;
  endtask

  task automatic check_post();
    logic [15:0] e;
    e = m_read(bus.address);
    if (!$isunknown(e)) chk("data_out_post", bus.data_out, e);
    chk("kbd_ready", bus.kbd_ready, m_rdy);
    chk("err_addr", bus.err_addr, m_err);
    if (scan_chk) begin
      chk("scan_valid", bus.scan_valid, m_present);
      if (m_present) begin
        chk("scan_addr", bus.scan_addr, m_ptr);
        if (!$isunknown(m_word)) chk("scan_data", bus.scan_data, m_word);
      end
      chk("frame_start", bus.frame_start, (m_present && m_ptr == 0));
    end
  endtask

  // One clock cycle: drive just after a rising edge, sample the combinational
  // read on the falling edge, then check registered state 1 ns after the edge.
  task automatic step(input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic kv, input logic [15:0] kc, input logic sr);
    logic [15:0] e;
    bus.address    = a;
    bus.write      = w;
    bus.data_in    = d;
    bus.kbd_valid  = kv;
    bus.kbd_code   = kc;
    bus.scan_ready = sr;
    @(negedge clk);
    pre_dout = bus.data_out;
    e = m_read(a);
    if (!$isunknown(e)) chk("data_out_pre", pre_dout, e);
    @(posedge clk);
    model_edge();
    #1;
    check_post();
  endtask

  task automatic do_reset();
    bus.write      = 1'b0;
    bus.kbd_valid  = 1'b0;
    bus.scan_ready = 1'b0;
    bus.address    = 16'd24576;
    #2 reset = 1'b1;
    #1;
    m_present = 1'b0;
    m_ptr     = 0;
    kbd_m     = 16'h0000;
    m_err     = 1'b0;
    m_rdy     = 1'b0;
    chk("rst_scan_valid", bus.scan_valid, 1'b0);
    chk("rst_scan_data", bus.scan_data, 16'h0000);
    chk("rst_scan_addr", bus.scan_addr, 13'd0);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_err_addr", bus.err_addr, 1'b0);
    chk("rst_kbd_ready", bus.kbd_ready, 1'b0);
    chk("rst_kbd_read", bus.data_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic stream_to(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (!(bus.scan_valid && int'(bus.scan_addr) == target) && n < budget) begin
      step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
      n++;
    end
    chk(name, (bus.scan_valid && int'(bus.scan_addr) == target), 1'b1);
  endtask

  initial begin
    tbl[0] = '{16'd5,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{16'd5,     1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1234, 1'b0};
    tbl[2] = '{16'd24577, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{16'd24576, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h0000, 16'h0041, 1'b0};
    tbl[4] = '{16'd24576, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0041, 16'h0000, 1'b0};
    tbl[5] = '{16'd24576, 1'b0, 16'h0000, 1'b1, 16'h0055, 1'b1, 16'h0000, 16'h0055, 1'b0};
    tbl[6] = '{16'd24576, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b1, 16'h0055, 16'h0055, 1'b0};
    tbl[7] = '{16'd24576, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h0055, 16'h0055, 1'b1};
    tbl[8] = '{16'd30000, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1};
    tbl[9] = '{16'd5,     1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h1234, 1'b1};

    bus.address    = 16'd0;
    bus.write      = 1'b0;
    bus.data_in    = 16'd0;
    bus.kbd_code   = 16'd0;
    bus.kbd_valid  = 1'b0;
    bus.scan_ready = 1'b0;

    do_reset();

    // First edge after release raises kbd_ready.
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("kbd_ready_after_release", bus.kbd_ready, 1'b1);

    // CPU / keyboard table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].kv, tbl[i].kc, 1'b0);
      if (tbl[i].chk_pre) chk($sformatf("tbl%0d_pre", i), pre_dout, tbl[i].pre);
      chk($sformatf("tbl%0d_post", i), bus.data_out, tbl[i].post);
      chk($sformatf("tbl%0d_err", i), bus.err_addr, tbl[i].err);
    end

    // Initialise low RAM and the whole screen.
    for (int i = 0; i < 256; i++) begin
      if (i != 5) step(16'(i), 1'b1, 16'($urandom), 1'b0, 16'd0, 1'b0);
    end
    for (int i = 0; i < 8192; i++) begin
      logic [15:0] d;
      d = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h00F0 : 16'($urandom);
      step(16'(16384 + i), 1'b1, d, 1'b0, 16'd0, 1'b0);
    end

    do_reset();
    scan_chk = 1'b1;

    // Stream the first two words with scan_ready held high.
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    chk("w0_valid", bus.scan_valid, 1'b1);
    chk("w0_addr", bus.scan_addr, 13'd0);
    chk("w0_data", bus.scan_data, 16'hFFFF);
    chk("w0_frame_start", bus.frame_start, 1'b1);
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    chk("gap_valid", bus.scan_valid, 1'b0);
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    chk("w1_valid", bus.scan_valid, 1'b1);
    chk("w1_addr", bus.scan_addr, 13'd1);
    chk("w1_data", bus.scan_data, 16'h00F0);
    chk("w1_frame_start", bus.frame_start, 1'b0);

    // Run to the end of the frame and across the wrap.
    stream_to(8191, 20000, "reach_8191");
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("wrap_addr", bus.scan_addr, 13'd0);
    chk("wrap_frame_start", bus.frame_start, 1'b1);
    chk("wrap_data", bus.scan_data, 16'hFFFF);

    // Stall on word 0 while the CPU clears screen[0].
    for (int k = 0; k < 10; k++) begin
      step(16'd16384, (k == 0), 16'h0000, 1'b0, 16'd0, 1'b0);
      chk("stall_valid", bus.scan_valid, 1'b1);
      chk("stall_data", bus.scan_data, 16'hFFFF);
      chk("stall_addr", bus.scan_addr, 13'd0);
    end
    chk("stall_cpu_read", bus.data_out, 16'h0000);
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);

    // Randomized traffic (screen word 0 left alone).
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a;
      logic        w;
      logic        kv;
      logic [15:0] kc;
      int          kind;
      kind = int'($urandom_range(0, 6));
      w    = 1'b0;
      case (kind)
        0: begin a = 16'($urandom_range(0, 255)); w = 1'b1; end
        1: a = 16'($urandom_range(0, 255));
        2: begin a = 16'($urandom_range(16385, 24575)); w = 1'b1; end
        3: a = 16'($urandom_range(16384, 24575));
        4: begin a = 16'd24576; w = ($urandom_range(0, 7) == 0); end
        5: begin a = 16'($urandom_range(24577, 65535)); w = ($urandom_range(0, 3) == 0); end
        default: a = 16'd24576;
      endcase
      kv = ($urandom_range(0, 3) == 0);
      kc = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      step(a, w, 16'($urandom), kv, kc, 1'($urandom_range(0, 1)));
    end

    // Next frame's word 0 shows the CPU's earlier write.
    stream_to(0, 20000, "reach_next_frame");
    chk("next_frame_data", bus.scan_data, 16'h0000);
    chk("next_frame_start", bus.frame_start, 1'b1);

    // Reset while presenting word 100, then restart at word 0.
    stream_to(100, 20000, "reach_100");
    do_reset();
    step(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    chk("restart_valid", bus.scan_valid, 1'b1);
    chk("restart_addr", bus.scan_addr, 13'd0);
    chk("restart_frame_start", bus.frame_start, 1'b1);
    chk("restart_data", bus.scan_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
